// File: rtl/df_i_mc_if.sv
// df_i_mc_if: sample, coefficient and result bus of the multichannel DF-I filter
interface df_i_mc_if #(
    parameter int N           = 2,
    parameter int CH_WIDTH    = 2,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int COEFF_WIDTH = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic [CH_WIDTH-1:0]            in_chan;
    logic signed [X_WIDTH-1:0]      x;
    logic [COEFF_WIDTH*(N+1)-1:0]   packed_b;
    logic [COEFF_WIDTH*N-1:0]       packed_a;
    logic                           flush;
    logic                           out_valid;
    logic [CH_WIDTH-1:0]            out_chan;
    logic signed [Y_WIDTH-1:0]      y;
    logic                           sat;

    modport master (
        output in_valid, in_chan, x, packed_b, packed_a, flush,
        input  in_ready, out_valid, out_chan, y, sat
    );

    modport slave (
        input  in_valid, in_chan, x, packed_b, packed_a, flush,
        output in_ready, out_valid, out_chan, y, sat
    );
endinterface

// File: rtl/df_i_mc.sv
// df_i_mc: time-multiplexed multichannel Nth-order direct form I IIR filter with one shared MAC
module df_i_mc #(
    parameter int N           = 2,
    parameter int CHANNELS    = 4,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int COEFF_WIDTH = 16,
    parameter int Q           = 14,
    parameter int ACC_WIDTH   = 40,
    parameter int CH_WIDTH    = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input logic        clk,
    input logic        rst_n,
    df_i_mc_if.slave   bus
);
    localparam int DW = X_WIDTH > Y_WIDTH ? X_WIDTH : Y_WIDTH;
    localparam int PW = COEFF_WIDTH + DW;
    localparam int TW = $clog2(2 * N + 1) > 0 ? $clog2(2 * N + 1) : 1;
    localparam logic [CH_WIDTH:0] NCH = CHANNELS[CH_WIDTH:0];
    localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (Q - 1);
    localparam logic signed [ACC_WIDTH-1:0] YMAX = (ACC_WIDTH'(1) << (Y_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                         state, state_nx;
    logic [CH_WIDTH-1:0]            chan, cidx;
    logic signed [X_WIDTH-1:0]      x_lat;
    logic [TW-1:0]                  tap;
    logic signed [ACC_WIDTH-1:0]    acc, sum, rnd, pext;
    logic signed [X_WIDTH-1:0]      xh [CHANNELS][N];
    logic signed [Y_WIDTH-1:0]      yh [CHANNELS][N];
    logic signed [COEFF_WIDTH-1:0]  coef;
    logic signed [DW-1:0]           dat;
    logic signed [PW-1:0]           prod;
    logic signed [Y_WIDTH-1:0]      y_nx;
    logic                           ch_ok, accept, do_flush, sub, hi, lo;
    logic                           ov_q, sat_q;
    logic [CH_WIDTH-1:0]            oc_q;
    logic signed [Y_WIDTH-1:0]      y_q;

    assign bus.in_ready  = state == IDLE && !bus.flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign do_flush      = state == IDLE && bus.flush;
    assign ch_ok         = {1'b0, chan} < NCH;
    assign cidx          = ch_ok ? chan : '0;
    assign sub           = tap > TW'(N);
    assign prod          = PW'(coef) * PW'(dat);
    assign pext          = ACC_WIDTH'(prod);
    assign sum           = acc + HALF;
    assign rnd           = sum >>> Q;
    assign hi            = rnd > YMAX;
    assign lo            = rnd < YMIN;
    assign y_nx          = hi ? YMAX[Y_WIDTH-1:0] : lo ? YMIN[Y_WIDTH-1:0] : rnd[Y_WIDTH-1:0];
    assign bus.out_valid = ov_q;
    assign bus.out_chan  = oc_q;
    assign bus.y         = y_q;
    assign bus.sat       = sat_q;

    // Tap operand select: b taps pair with x history, a taps with y history
    always_comb begin
        coef = bus.packed_b[COEFF_WIDTH-1:0];
        dat  = DW'(x_lat);
        for (int k = 1; k <= N; k++) begin
            if (tap == TW'(k)) begin
                coef = bus.packed_b[COEFF_WIDTH*k +: COEFF_WIDTH];
                dat  = DW'(xh[cidx][k-1]);
            end
            if (tap == TW'(N + k)) begin
                coef = bus.packed_a[COEFF_WIDTH*(k-1) +: COEFF_WIDTH];
                dat  = DW'(yh[cidx][k-1]);
            end
        end
    end

    // Next state: accept in IDLE, walk 2N+1 taps, then one output cycle
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (accept ? MAC : IDLE)
                 : state == MAC  ? (tap == TW'(2 * N) ? OUT : MAC)
                 : IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Datapath: sample latch, MAC accumulation, output registers and channel histories
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan  <= '0;
            x_lat <= '0;
            tap   <= '0;
            acc   <= '0;
            ov_q  <= 1'b0;
            oc_q  <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                for (int j = 0; j < N; j++) begin
                    xh[c][j] <= '0;
                    yh[c][j] <= '0;
                end
        end else begin
            ov_q <= 1'b0;
            if (accept) begin
                chan  <= bus.in_chan;
                x_lat <= bus.x;
                tap   <= '0;
                acc   <= '0;
            end
            if (state == MAC) begin
                acc <= sub ? acc - pext : acc + pext;
                tap <= tap + TW'(1);
            end
            if (state == OUT && ch_ok) begin
                ov_q  <= 1'b1;
                oc_q  <= chan;
                y_q   <= y_nx;
                sat_q <= hi || lo;
                for (int j = N - 1; j > 0; j--) begin
                    xh[cidx][j] <= xh[cidx][j-1];
                    yh[cidx][j] <= yh[cidx][j-1];
                end
                xh[cidx][0] <= x_lat;
                yh[cidx][0] <= y_nx;
            end
            if (do_flush)
                for (int c = 0; c < CHANNELS; c++)
                    for (int j = 0; j < N; j++) begin
                        xh[c][j] <= '0;
                        yh[c][j] <= '0;
                    end
        end
    end
endmodule
